// File: rtl/cp0_vec_irq.sv
// Vectored CP0: sticky pending bits, per-source mask, fixed-priority take, Status/Cause/EPC via mfc0/mtc0, eret.
// Take and redirect are combinational in the exception cycle; enable=0 freezes architectural state but keeps latching pend.
module cp0_vec_irq #(
  parameter int unsigned       N_SRC      = 4,
  parameter logic [31:0]       VEC_BASE   = 32'h0040_0100,
  parameter logic [31:0]       VEC_STRIDE = 32'h0000_0020,
  parameter logic [N_SRC-1:0]  RESET_MASK = {N_SRC{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       Inst,
  input  logic [31:0]       PCin,
  input  logic [31:0]       Din,
  input  logic [N_SRC-1:0]  ExpSrc,
  input  logic              enable,
  output logic              ExRegWrite,
  output logic              IsEret,
  output logic              HasExp,
  output logic              ExpBlock,
  output logic [31:0]       PCout,
  output logic [31:0]       Dout
);

  localparam logic NORMAL  = 1'b0;
  localparam logic HANDLER = 1'b1;

  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;

  logic             ie_q, ie_d;
  logic             exl_q, exl_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [4:0]       code_q, code_d;
  logic [31:0]      epc_q, epc_d;

  logic             is_cop0, is_mfc0, is_mtc0, is_eret;
  logic [4:0]       rs, rd;
  logic [N_SRC-1:0] req, take_oh, w1c;
  logic [4:0]       idx;
  logic             found;
  logic             wr_en;
  logic [31:0]      status_rd, cause_rd, vec_addr;
  logic             unused_inst_bits;

  assign unused_inst_bits = ^{Inst[20:16], Inst[10:6]};

  assign rs      = Inst[25:21];
  assign rd      = Inst[15:11];
  assign is_cop0 = (Inst[31:26] == 6'b010000);
  assign is_mfc0 = is_cop0 && (rs == 5'b00000);
  assign is_mtc0 = is_cop0 && (rs == 5'b00100);
  assign is_eret = is_cop0 && (rs == 5'b10000) && (Inst[5:0] == 6'b011000);

  assign ExRegWrite = is_mfc0;
  assign IsEret     = is_eret;
  assign ExpBlock   = exl_q;

  assign req    = pend_q & mask_q;
  assign HasExp = enable && ie_q && (exl_q == NORMAL) && (|req);

  // Lowest set request bit wins.
  always_comb begin
    idx     = '0;
    take_oh = '0;
    found   = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (req[i] && !found) begin
        found      = 1'b1;
        idx        = 5'(i);
        take_oh[i] = HasExp;
      end
    end
  end

  assign vec_addr = VEC_BASE + (32'(idx) * VEC_STRIDE);
  assign PCout    = HasExp ? vec_addr : epc_q;

  always_comb begin
    status_rd              = '0;
    status_rd[0]           = ie_q;
    status_rd[1]           = exl_q;
    status_rd[8 +: N_SRC]  = mask_q;
    cause_rd               = '0;
    cause_rd[6:2]          = code_q;
    cause_rd[8 +: N_SRC]   = pend_q;
  end

  always_comb begin
    case (rd)
      REG_STATUS: Dout = status_rd;
      REG_CAUSE:  Dout = cause_rd;
      REG_EPC:    Dout = epc_q;
      default:    Dout = 32'h0;
    endcase
  end

  // A taken exception suppresses any mtc0 issued in the same cycle.
  assign wr_en = enable && is_mtc0 && !HasExp;
  assign w1c   = (wr_en && (rd == REG_CAUSE)) ? Din[8 +: N_SRC] : '0;

  always_comb begin
    // New requests beat a same-cycle W1C; the take clear beats everything.
    pend_d = ((pend_q & ~w1c) | ExpSrc) & ~take_oh;
    ie_d   = ie_q;
    exl_d  = exl_q;
    mask_d = mask_q;
    code_d = code_q;
    epc_d  = epc_q;
    if (HasExp) begin
      exl_d  = HANDLER;
      code_d = idx;
      epc_d  = PCin;
    end else if (enable && is_eret) begin
      exl_d = NORMAL;
    end else if (wr_en) begin
      case (rd)
        REG_STATUS: begin
          ie_d   = Din[0];
          exl_d  = Din[1] ? HANDLER : NORMAL;
          mask_d = Din[8 +: N_SRC];
        end
        REG_EPC:    epc_d = Din;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ie_q   <= 1'b0;
      exl_q  <= NORMAL;
      mask_q <= RESET_MASK;
      pend_q <= '0;
      code_q <= '0;
      epc_q  <= '0;
    end else begin
      ie_q   <= ie_d;
      exl_q  <= exl_d;
      mask_q <= mask_d;
      pend_q <= pend_d;
      code_q <= code_d;
      epc_q  <= epc_d;
    end
  end

endmodule

// File: tb/tb_cp0_vec_irq.sv
module tb_cp0_vec_irq;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Inst, PCin, Din;
  logic [3:0]  ExpSrc;
  logic        enable;
  logic        ExRegWrite, IsEret, HasExp, ExpBlock;
  logic [31:0] PCout, Dout;

  int tests = 0;
  int fails = 0;

  cp0_vec_irq dut (
    .clk(clk), .reset(reset), .Inst(Inst), .PCin(PCin), .Din(Din),
    .ExpSrc(ExpSrc), .enable(enable), .ExRegWrite(ExRegWrite), .IsEret(IsEret),
    .HasExp(HasExp), .ExpBlock(ExpBlock), .PCout(PCout), .Dout(Dout)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] ERET = 32'h4200_0018;
  localparam logic [31:0] NOP  = 32'h0000_0000;

  function automatic logic [31:0] mfc0(input logic [4:0] rd);
    return {6'b010000, 5'b00000, 5'd2, rd, 11'b0};
  endfunction

  function automatic logic [31:0] mtc0(input logic [4:0] rd);
    return {6'b010000, 5'b00100, 5'd2, rd, 11'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic rd_reg(input string tag, input logic [4:0] rd, input logic [31:0] exp);
    Inst = mfc0(rd);
    #1;
    chk(tag, Dout, exp);
  endtask

  initial begin
    reset = 1'b1; Inst = NOP; PCin = '0; Din = '0; ExpSrc = '0; enable = 1'b1;
    tick();
    reset = 1'b0;

    // Reset state
    Inst = mfc0(5'd12); #1;
    chk1("rst_exregwrite", ExRegWrite, 1'b1);
    chk1("rst_iseret", IsEret, 1'b0);
    chk1("rst_hasexp", HasExp, 1'b0);
    chk1("rst_expblock", ExpBlock, 1'b0);
    chk("rst_status", Dout, 32'h0000_0F00);
    rd_reg("rst_cause", 5'd13, 32'h0);
    rd_reg("rst_epc", 5'd14, 32'h0);
    rd_reg("unmapped_rd15", 5'd15, 32'h0);

    // Masked pulse with IE=0
    Inst = NOP; ExpSrc = 4'b0100;
    tick();
    ExpSrc = 4'b0000; #1;
    chk1("ie0_hasexp", HasExp, 1'b0);
    rd_reg("ie0_cause", 5'd13, 32'h0000_0400);
    tick();
    rd_reg("ie0_cause_sticky", 5'd13, 32'h0000_0400);
    Inst = mtc0(5'd12); Din = 32'h0000_0F01; #1;
    chk1("ie_wr_cycle_hasexp", HasExp, 1'b0);
    tick();
    Inst = NOP; PCin = 32'h0040_0010; #1;
    chk1("ie1_hasexp", HasExp, 1'b1);
    chk("ie1_pcout", PCout, 32'h0040_0140);
    rd_reg("ie1_status", 5'd12, 32'h0000_0F01);
    tick();
    chk1("take2_expblock", ExpBlock, 1'b1);
    rd_reg("take2_cause", 5'd13, 32'h0000_0008);
    rd_reg("take2_epc", 5'd14, 32'h0040_0010);
    Inst = ERET; #1;
    chk1("eret1_iseret", IsEret, 1'b1);
    chk("eret1_pcout", PCout, 32'h0040_0010);
    tick();
    chk1("eret1_expblock", ExpBlock, 1'b0);

    // Priority
    Inst = NOP; ExpSrc = 4'b1010;
    tick();
    ExpSrc = 4'b0000; PCin = 32'h0040_0040; #1;
    chk1("prio_hasexp", HasExp, 1'b1);
    chk("prio_pcout", PCout, 32'h0040_0120);
    tick();
    chk1("prio_expblock", ExpBlock, 1'b1);
    chk1("prio_hasexp_after", HasExp, 1'b0);
    rd_reg("prio_epc", 5'd14, 32'h0040_0040);
    rd_reg("prio_cause", 5'd13, 32'h0000_0804);

    // Nesting blocked, then eret
    Inst = NOP; ExpSrc = 4'b0001;
    tick();
    ExpSrc = 4'b0000; #1;
    chk1("nest_hasexp", HasExp, 1'b0);
    Inst = ERET; #1;
    chk1("nest_eret_iseret", IsEret, 1'b1);
    chk1("nest_eret_hasexp", HasExp, 1'b0);
    chk("nest_eret_pcout", PCout, 32'h0040_0040);
    tick();
    Inst = NOP; PCin = 32'h0040_0080; #1;
    chk1("nest_exl0", ExpBlock, 1'b0);
    chk1("nest_hasexp_after", HasExp, 1'b1);
    chk("nest_pcout", PCout, 32'h0040_0100);
    tick();
    rd_reg("nest_cause", 5'd13, 32'h0000_0800);
    Inst = ERET;
    tick();

    // Stall
    enable = 1'b0; Inst = NOP; ExpSrc = 4'b0100; PCin = 32'h0040_0200; #1;
    chk1("stall_hasexp", HasExp, 1'b0);
    tick();
    ExpSrc = 4'b0000;
    rd_reg("stall_epc", 5'd14, 32'h0040_0080);
    chk1("stall_exregwrite", ExRegWrite, 1'b1);
    rd_reg("stall_cause", 5'd13, 32'h0000_0C00);
    Inst = mtc0(5'd14); Din = 32'h1234_5678;
    tick();
    rd_reg("stall_mtc0_dropped", 5'd14, 32'h0040_0080);
    enable = 1'b1; Inst = NOP; PCin = 32'h0040_00C0; #1;
    chk1("unstall_hasexp", HasExp, 1'b1);
    chk("unstall_pcout", PCout, 32'h0040_0140);
    tick();
    rd_reg("unstall_epc", 5'd14, 32'h0040_00C0);
    rd_reg("unstall_cause", 5'd13, 32'h0000_0808);

    // Collision: exception beats same-cycle mtc0 EPC
    Inst = mtc0(5'd12); Din = 32'h0000_0F01;
    tick();
    Inst = mtc0(5'd14); Din = 32'hDEAD_BEE0; PCin = 32'h0040_0300; #1;
    chk1("coll_hasexp", HasExp, 1'b1);
    chk("coll_pcout", PCout, 32'h0040_0160);
    tick();
    Inst = mfc0(5'd14); #1;
    chk1("coll_exregwrite", ExRegWrite, 1'b1);
    chk("coll_epc", Dout, 32'h0040_0300);
    rd_reg("coll_cause", 5'd13, 32'h0000_000C);

    // W1C clears pending; code field read-only; set beats W1C
    Inst = NOP; ExpSrc = 4'b0011;
    tick();
    ExpSrc = 4'b0000; Inst = mtc0(5'd13); Din = 32'h0000_017C;
    tick();
    rd_reg("w1c_cause", 5'd13, 32'h0000_020C);
    Inst = mtc0(5'd13); Din = 32'h0000_0200; ExpSrc = 4'b0010;
    tick();
    ExpSrc = 4'b0000;
    rd_reg("setwins_cause", 5'd13, 32'h0000_020C);

    // Status field isolation and masking
    Inst = mtc0(5'd12); Din = 32'hFFFF_FFFF;
    tick();
    rd_reg("status_all_ones", 5'd12, 32'h0000_0F03);
    Inst = mtc0(5'd12); Din = 32'h0000_0D01;
    tick();
    Inst = NOP; #1;
    chk1("masked_hasexp", HasExp, 1'b0);
    chk1("masked_expblock", ExpBlock, 1'b0);
    Inst = mtc0(5'd12); Din = 32'h0000_0F01;
    tick();
    Inst = NOP; #1;
    chk1("unmasked_hasexp", HasExp, 1'b1);
    chk("unmasked_pcout", PCout, 32'h0040_0120);

    // Reset wins over same-cycle mtc0 and exception
    reset = 1'b1; Inst = mtc0(5'd14); Din = 32'h0000_0055; PCin = 32'h0040_0400;
    tick();
    reset = 1'b0;
    rd_reg("rst2_epc", 5'd14, 32'h0);
    rd_reg("rst2_status", 5'd12, 32'h0000_0F00);
    rd_reg("rst2_cause", 5'd13, 32'h0);
    chk1("rst2_expblock", ExpBlock, 1'b0);

    // eret with EXL=0 redirects to EPC, EXL stays 0
    Inst = ERET; #1;
    chk1("eret0_iseret", IsEret, 1'b1);
    chk("eret0_pcout", PCout, 32'h0);
    tick();
    chk1("eret0_expblock", ExpBlock, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
